// File: rtl/traffic_pkg.sv
// Shared types for the intersection sequencer: state encoding, per-phase lamp
// codes and the 7-segment digit table used by the board display logic.
package traffic_pkg;

  typedef enum logic [2:0] {
    ST_OFF,
    ST_INIT,
    ST_GREEN,
    ST_YELLOW,
    ST_CLEAR
  } state_t;

  // Lamp codes packed as {red, yellow, green}
  localparam logic [2:0] LAMP_R = 3'b100;
  localparam logic [2:0] LAMP_Y = 3'b010;
  localparam logic [2:0] LAMP_G = 3'b001;

  // Active-low segments ordered {g,f,e,d,c,b,a}
  function automatic logic [6:0] seg7_digit(input logic [3:0] digit);
    logic [6:0] seg;
    case (digit)
      4'd0:    seg = 7'b1000000;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0010000;
      default: seg = 7'b0111111;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/tick_divider.sv
// Free-running clock divider producing a one-cycle tick every TICK_CYCLES
// cycles while run is high; clear restarts the count from zero.
module tick_divider #(
  parameter int TICK_CYCLES = 100_000_000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic run,
  input  logic clear,
  output logic tick
);

  localparam int DW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [DW-1:0] LAST = DW'(TICK_CYCLES - 1);

  logic [DW-1:0] count_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (run) begin
      count_reg <= (count_reg == LAST) ? '0 : count_reg + 1'b1;
    end
  end

  assign tick = run && (count_reg == LAST);

endmodule

// File: rtl/traffic_phase_controller.sv
// N-phase intersection sequencer: GREEN -> YELLOW -> CLEAR per phase, with
// pedestrian WALK service, demand-based phase skipping, pause and manual stepping.
module traffic_phase_controller
  import traffic_pkg::*;
#(
  parameter int NUM_PHASES  = 4,
  parameter int TICK_CYCLES = 100_000_000,
  parameter int GREEN_SECS  = 5,
  parameter int YELLOW_SECS = 1,
  parameter int CLEAR_SECS  = 1,
  parameter int WALK_SECS   = 3,
  parameter int SKIP_EN     = 1,
  parameter int CNT_W       = 4
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          enable,
  input  logic                          auto_mode,
  input  logic                          pause_pulse,
  input  logic                          step_pulse,
  input  logic [NUM_PHASES-1:0]         ped_req,
  input  logic [NUM_PHASES-1:0]         det_req,
  output logic [NUM_PHASES-1:0]         red,
  output logic [NUM_PHASES-1:0]         yellow,
  output logic [NUM_PHASES-1:0]         green,
  output logic [NUM_PHASES-1:0]         walk,
  output logic [$clog2(NUM_PHASES)-1:0] active_phase,
  output logic [CNT_W-1:0]              countdown,
  output logic                          count_valid
);

  localparam int PW = $clog2(NUM_PHASES);

  state_t                  state_reg;
  logic [PW-1:0]           phase_reg;
  logic [CNT_W-1:0]        countdown_reg;
  logic [CNT_W-1:0]        walk_cnt_reg;
  logic [NUM_PHASES-1:0]   ped_lat_reg;
  logic [NUM_PHASES-1:0]   ped_lat_next;
  logic [NUM_PHASES-1:0]   ped_clr;
  logic                    paused_reg;
  logic                    count_valid_reg;
  logic                    tick;
  logic                    run;
  logic                    advance;
  logic                    div_clear;
  logic                    green_entry;
  logic                    walk_start;
  logic [PW-1:0]           green_target;

  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
    return (p == PW'(NUM_PHASES - 1)) ? '0 : p + 1'b1;
  endfunction

  // First phase after p (round-robin, may wrap back to p) with demand; else p+1
  function automatic logic [PW-1:0] next_phase(input logic [PW-1:0] p,
                                               input logic [NUM_PHASES-1:0] demand);
    logic [PW-1:0] q;
    logic [PW-1:0] pick;
    logic          found;
    pick  = wrap_inc(p);
    q     = p;
    found = 1'b0;
    if (SKIP_EN != 0) begin
      for (int i = 0; i < NUM_PHASES; i++) begin
        q = wrap_inc(q);
        if (!found && demand[q]) begin
          pick  = q;
          found = 1'b1;
        end
      end
    end
    return pick;
  endfunction

  assign run       = enable && auto_mode && !paused_reg && (state_reg != ST_OFF);
  assign advance   = enable && (state_reg != ST_OFF) &&
                     (auto_mode ? (tick && (countdown_reg == '0)) : step_pulse);
  assign div_clear = !enable || !auto_mode || (state_reg == ST_OFF) || advance;

  tick_divider #(
    .TICK_CYCLES(TICK_CYCLES)
  ) u_tick_divider (
    .clk    (clk),
    .reset_n(reset_n),
    .run    (run),
    .clear  (div_clear),
    .tick   (tick)
  );

  assign green_entry  = advance && ((state_reg == ST_INIT) || (state_reg == ST_CLEAR));
  assign green_target = (state_reg == ST_INIT) ? '0 : next_phase(phase_reg, det_req | ped_lat_reg);
  assign walk_start   = green_entry && ped_lat_reg[green_target];

  // A request arriving on the same cycle as its GREEN entry stays latched
  always_comb begin
    ped_clr = '0;
    if (green_entry) ped_clr[green_target] = 1'b1;
    ped_lat_next = (ped_lat_reg & ~ped_clr) | ped_req;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg       <= ST_INIT;
      phase_reg       <= '0;
      countdown_reg   <= CNT_W'(CLEAR_SECS);
      walk_cnt_reg    <= '0;
      ped_lat_reg     <= '0;
      paused_reg      <= 1'b0;
      count_valid_reg <= 1'b0;
    end else begin
      ped_lat_reg     <= ped_lat_next;
      count_valid_reg <= enable && auto_mode;

      if (!enable || !auto_mode) paused_reg <= 1'b0;
      else if (pause_pulse)      paused_reg <= !paused_reg;

      if (!enable) begin
        state_reg     <= ST_OFF;
        phase_reg     <= '0;
        countdown_reg <= '0;
        walk_cnt_reg  <= '0;
      end else if (state_reg == ST_OFF) begin
        state_reg     <= ST_INIT;
        countdown_reg <= CNT_W'(CLEAR_SECS);
      end else if (advance) begin
        walk_cnt_reg <= '0;
        case (state_reg)
          ST_INIT, ST_CLEAR: begin
            state_reg     <= ST_GREEN;
            phase_reg     <= green_target;
            countdown_reg <= CNT_W'(GREEN_SECS);
            if (walk_start) walk_cnt_reg <= CNT_W'(WALK_SECS);
          end
          ST_GREEN: begin
            state_reg     <= ST_YELLOW;
            countdown_reg <= CNT_W'(YELLOW_SECS);
          end
          ST_YELLOW: begin
            state_reg     <= ST_CLEAR;
            countdown_reg <= CNT_W'(CLEAR_SECS);
          end
          default: state_reg <= ST_INIT;
        endcase
      end else if (tick) begin
        if (countdown_reg != '0) countdown_reg <= countdown_reg - 1'b1;
        if ((state_reg == ST_GREEN) && (walk_cnt_reg != '0)) walk_cnt_reg <= walk_cnt_reg - 1'b1;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PHASES; gi++) begin : g_lamp
      logic       owned;
      logic [2:0] lamp;
      assign owned = (phase_reg == PW'(gi));
      always_comb begin
        lamp = LAMP_R;
        if (owned && (state_reg == ST_GREEN))       lamp = LAMP_G;
        else if (owned && (state_reg == ST_YELLOW)) lamp = LAMP_Y;
      end
      assign {red[gi], yellow[gi], green[gi]} = lamp;
      assign walk[gi] = owned && (state_reg == ST_GREEN) && (walk_cnt_reg != '0);
    end
  endgenerate

  assign active_phase = phase_reg;
  assign countdown    = countdown_reg;
  assign count_valid  = count_valid_reg;

endmodule
